// File: rtl/psum_bram_reader.sv
// psum_bram_reader
//   Streams a programmed range of psum BRAM words to a downstream consumer
//   over a valid/ready handshake. It hides the 1-cycle BRAM read latency
//   and absorbs backpressure with a 4-entry FIFO. It sustains one word per
//   cycle while the consumer stays ready.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   start          : one-cycle pulse, sampled only in IDLE
//   base_addr      : first BRAM address, latched on start
//   num_words      : word count 0..1024, latched on start
//   psum_read_en   : BRAM read enable
//   psum_BRAM_addr : BRAM read address, held while psum_read_en is low
//   bram_rdata     : BRAM read data, valid the cycle after psum_read_en
//   out_data       : FIFO head word
//   out_valid      : out_data valid
//   out_ready      : consumer accept
//   out_last       : high with out_valid on the final word of the range
//   busy           : high in any state other than IDLE
//   read_done      : one-cycle pulse at completion
module psum_bram_reader #(
  parameter int GBF_DATA_BITWIDTH  = 512,
  parameter int BRAM_ADDR_BITWIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [BRAM_ADDR_BITWIDTH-1:0]   base_addr,
  input  logic [BRAM_ADDR_BITWIDTH:0]     num_words,
  output logic                            psum_read_en,
  output logic [BRAM_ADDR_BITWIDTH-1:0]   psum_BRAM_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0]    bram_rdata,
  output logic [GBF_DATA_BITWIDTH-1:0]    out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            read_done
);

  localparam int AW = BRAM_ADDR_BITWIDTH;
  localparam int DW = GBF_DATA_BITWIDTH;
  localparam int CW = BRAM_ADDR_BITWIDTH + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   base_r;
  logic [CW-1:0]   num_r;
  logic [CW-1:0]   issued_r;
  logic [CW-1:0]   delivered_r;
  // High while the data for last cycle's read is on bram_rdata; it is
  // captured into the FIFO at the end of this cycle.
  logic            inflight_r;

  logic [DW-1:0]   fifo_mem_r [4];
  logic [1:0]      wr_ptr_r;
  logic [1:0]      rd_ptr_r;
  logic [2:0]      count_r;

  logic            push_s;
  logic            pop_s;
  logic [2:0]      count_next_s;
  logic [1:0]      rd_ptr_next_s;
  logic [CW-1:0]   delivered_next_s;
  logic            can_issue_s;
  logic [DW-1:0]   head_next_s;
  logic            last_next_s;

  // Next-cycle FIFO occupancy, head word and issue budget.
  always_comb begin
    push_s           = inflight_r;
    pop_s            = out_valid && out_ready;
    count_next_s     = count_r + {2'b00, push_s} - {2'b00, pop_s};
    rd_ptr_next_s    = rd_ptr_r + {1'b0, pop_s};
    delivered_next_s = delivered_r + {{AW{1'b0}}, pop_s};
    // The read enable being driven now becomes next cycle's in-flight read,
    // so the budget for next cycle's read counts it alongside the FIFO.
    can_issue_s      = ((count_next_s + {2'b00, psum_read_en}) <= 3'd2);
    if (count_next_s == 3'd0) begin
      head_next_s = out_data;
    end else if (count_r == {2'b00, pop_s}) begin
      // FIFO drains to empty this edge, so the new head is the word being
      // pushed right now (it is also written into the slot at rd_ptr_next).
      head_next_s = bram_rdata;
    end else begin
      head_next_s = fifo_mem_r[rd_ptr_next_s];
    end
    if ((count_next_s != 3'd0) && (delivered_next_s == (num_r - CNT_ONE))) begin
      last_next_s = 1'b1;
    end else begin
      last_next_s = 1'b0;
    end
  end

  // Control FSM: range latch, read issue, completion and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      base_r         <= {AW{1'b0}};
      num_r          <= {CW{1'b0}};
      issued_r       <= {CW{1'b0}};
      psum_read_en   <= 1'b0;
      psum_BRAM_addr <= {AW{1'b0}};
      busy           <= 1'b0;
      read_done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          read_done <= 1'b0;
          if (start) begin
            base_r <= base_addr;
            num_r  <= num_words;
            busy   <= 1'b1;
            if (num_words == {CW{1'b0}}) begin
              psum_read_en <= 1'b0;
              issued_r     <= {CW{1'b0}};
              read_done    <= 1'b1;
              state_r      <= DONE;
            end else begin
              // First read goes out in the cycle right after start.
              psum_read_en   <= 1'b1;
              psum_BRAM_addr <= base_addr;
              issued_r       <= CNT_ONE;
              state_r        <= READ;
            end
          end else begin
            psum_read_en <= 1'b0;
            busy         <= 1'b0;
          end
        end
        READ: begin
          if ((issued_r < num_r) && can_issue_s) begin
            psum_read_en   <= 1'b1;
            psum_BRAM_addr <= base_r + issued_r[AW-1:0];
            issued_r       <= issued_r + CNT_ONE;
            if ((issued_r + CNT_ONE) == num_r) begin
              state_r <= DRAIN;
            end else begin
              state_r <= READ;
            end
          end else begin
            psum_read_en <= 1'b0;
            if (issued_r == num_r) begin
              state_r <= DRAIN;
            end else begin
              state_r <= READ;
            end
          end
        end
        DRAIN: begin
          psum_read_en <= 1'b0;
          if (pop_s && out_last) begin
            read_done <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          psum_read_en <= 1'b0;
          read_done    <= 1'b0;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          psum_read_en <= 1'b0;
          read_done    <= 1'b0;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage, occupancy, deliver counter and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r    <= 2'd0;
      rd_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      inflight_r  <= 1'b0;
      delivered_r <= {CW{1'b0}};
      out_data    <= {DW{1'b0}};
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      inflight_r <= psum_read_en;
      // Capture is unconditional: the issue budget keeps the FIFO from overflowing.
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bram_rdata;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r  <= rd_ptr_next_s;
      count_r   <= count_next_s;
      out_valid <= (count_next_s != 3'd0);
      out_data  <= head_next_s;
      out_last  <= last_next_s;
      if ((state_r == IDLE) && start) begin
        delivered_r <= {CW{1'b0}};
      end else begin
        delivered_r <= delivered_next_s;
      end
    end
  end

endmodule

// File: tb/tb_psum_bram_reader.sv
// Self-checking bench for psum_bram_reader: a BRAM model, a queue-based
// reference of the expected word stream, and a per-cycle compare process.
module tb_psum_bram_reader;

  localparam int DW = 512;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          psum_read_en;
  logic [AW-1:0] psum_BRAM_addr;
  logic [DW-1:0] bram_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          read_done;

  psum_bram_reader #(.GBF_DATA_BITWIDTH(DW), .BRAM_ADDR_BITWIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .psum_read_en(psum_read_en),
    .psum_BRAM_addr(psum_BRAM_addr), .bram_rdata(bram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .read_done(read_done)
  );

  always #5 clk = ~clk;

  // BRAM model with one cycle of read latency
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (psum_read_en) bram_rdata <= mem[psum_BRAM_addr];
  end

  // Consumer ready pattern: 0 always ready, 1 = 1,0,0,1 repeating, 2 random
  int ready_mode = 0;
  int cyc = 0;
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check_bit(string name, logic act, logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_int(string name, int act, int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_word(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model state (written only by the compare process)
  logic [DW-1:0] exp_q[$];
  int            busy_m = 0, done_due = 0, count_m = 0, infl_m = 0;
  int            issued_m = 0, n_m = 0, base_m = 0, deliv_m = 0;
  int            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Per-cycle compare against the reference model
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_int("reset_ctl", int'({psum_read_en, psum_BRAM_addr, out_valid, out_last, busy, read_done}), 0);
        check_word("reset_data", out_data, '0);
        exp_q.delete();
        busy_m = 0; done_due = 0; count_m = 0; infl_m = 0;
        issued_m = 0; n_m = 0; prev_stall = 0;
      end else begin
        int   busy_old;
        logic pop;
        logic last_hs;
        busy_old = busy_m;
        check_bit("busy", busy, busy_m != 0);
        check_bit("read_done", read_done, done_due != 0);
        check_bit("out_valid", out_valid, count_m != 0);
        if (out_valid) begin
          check_bit("word_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check_word("out_data", out_data, exp_q[0]);
            check_bit("out_last", out_last, exp_q.size() == 1);
          end
        end
        if (prev_stall != 0) begin
          check_bit("stall_valid", out_valid, 1'b1);
          check_bit("stall_last", out_last, prev_last);
          check_word("stall_data", out_data, prev_data);
        end
        if (psum_read_en) begin
          check_int("read_addr", int'(psum_BRAM_addr), (base_m + issued_m) % 1024);
          check_bit("read_in_range", issued_m < n_m, 1'b1);
          check_bit("issue_budget", (count_m + infl_m) <= 2, 1'b1);
          issued_m++;
        end
        pop = out_valid && out_ready;
        last_hs = 1'b0;
        if (pop && (exp_q.size() != 0)) begin
          if (exp_q.size() == 1) last_hs = 1'b1;
          void'(exp_q.pop_front());
          deliv_m++;
        end
        prev_stall = (out_valid && !out_ready) ? 1 : 0;
        prev_data  = out_data;
        prev_last  = out_last;
        count_m    = count_m + infl_m - (pop ? 1 : 0);
        infl_m     = psum_read_en ? 1 : 0;
        if (done_due != 0) begin
          busy_m = 0;
          done_due = 0;
        end
        if (last_hs) done_due = 1;
        if (start && (busy_old == 0)) begin
          base_m = int'(base_addr);
          n_m = int'(num_words);
          issued_m = 0;
          deliv_m = 0;
          busy_m = 1;
          exp_q.delete();
          for (int k = 0; k < n_m; k++) exp_q.push_back(mem[(base_m + k) % 1024]);
          if (n_m == 0) done_due = 1;
        end
      end
    end
  end

  task automatic do_start(input int b, input int n);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(b);
    num_words = (AW + 1)'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((busy !== 1'b0) && (t < 6000));
    check_bit("idle_reached", t < 6000, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    for (int i = 0; i < 1024; i++) begin
      w = 32'(i);
      mem[i] = {16{w}};
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Idle after reset with no start
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_int("idle_ctl", int'({psum_read_en, psum_BRAM_addr, out_valid, out_last, busy, read_done}), 0);
    end

    // Basic stream: 8 words from address 0, consumer always ready
    ready_mode = 0;
    do_start(0, 8);
    @(negedge clk); check_bit("lat_c1", out_valid, 1'b0);
    @(negedge clk); check_bit("lat_c2", out_valid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      w = 32'(k);
      check_bit("basic_valid", out_valid, 1'b1);
      check_word("basic_word", out_data, {16{w}});
      check_bit("basic_last", out_last, k == 7);
    end
    @(negedge clk);
    check_bit("basic_done", read_done, 1'b1);
    check_bit("basic_busy_done", busy, 1'b1);
    @(negedge clk);
    check_bit("basic_done_off", read_done, 1'b0);
    check_bit("basic_busy_off", busy, 1'b0);

    // Backpressure: 1,0,0,1 ready pattern
    ready_mode = 1;
    do_start(100, 16);
    wait_idle();
    check_int("bp_count", deliv_m, 16);

    // Wrap-around 1020..3
    ready_mode = 0;
    do_start(1020, 8);
    begin
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while ((out_last !== 1'b1) && (t < 100));
      check_bit("wrap_last_seen", out_last, 1'b1);
      w = 32'd3;
      check_word("wrap_last_word", out_data, {16{w}});
    end
    wait_idle();
    check_int("wrap_count", deliv_m, 8);

    // Zero length
    do_start(5, 0);
    @(negedge clk);
    check_bit("zero_done", read_done, 1'b1);
    check_bit("zero_no_read", psum_read_en, 1'b0);
    @(negedge clk);
    check_bit("zero_busy_off", busy, 1'b0);

    // Start while busy is ignored
    do_start(0, 8);
    repeat (3) @(posedge clk);
    do_start(50, 4);
    wait_idle();
    check_int("ignored_start_count", deliv_m, 8);

    // Reset mid-run after 3 words, then a fresh 2-word run
    do_start(0, 8);
    begin
      int t = 0;
      do begin
        @(negedge clk);
        #1;
        t++;
      end while ((deliv_m < 3) && (t < 100));
      check_bit("mid_three_seen", deliv_m >= 3, 1'b1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_bit("mid_valid_off", out_valid, 1'b0);
    check_bit("mid_busy_off", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    do_start(0, 2);
    wait_idle();
    check_int("after_reset_count", deliv_m, 2);

    // Randomized runs over random BRAM contents
    for (int i = 0; i < 1024; i++) begin
      for (int j = 0; j < 16; j++) mem[i][j*32 +: 32] = $urandom;
    end
    ready_mode = 2;
    for (int r = 0; r < 14; r++) begin
      int b, n;
      b = $urandom_range(0, 1023);
      n = (r == 5) ? 1024 : $urandom_range(0, 40);
      do_start(b, n);
      if ((r % 3) == 1) do_start($urandom_range(0, 1023), $urandom_range(1, 8));
      wait_idle();
      check_int("rand_count", deliv_m, n);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
